// File: rtl/hud_pkg.sv
// Shared constants, lookup tables and state encoding for the HUD score writer.
package hud_pkg;

  localparam int unsigned NUM_FIELDS = 6;
  localparam int unsigned NUM_SLOTS  = 14;

  localparam logic [2:0]  LAST_FIELD = 3'd5;
  localparam logic [13:0] SCORE_MAX  = 14'd9999;
  localparam logic [6:0]  VAL_MAX    = 7'd99;

  // Eight entries so any 3-bit field index is in range; entries 6 and 7 are never used.
  localparam logic [7:0][3:0] BASE_SLOT = {4'd0, 4'd0, 4'd12, 4'd10, 4'd8, 4'd6, 4'd4, 4'd0};
  localparam logic [7:0][2:0] DIGIT_CNT = {3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd4};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CONV,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary to 4 BCD digits, fixed
// 14-cycle start-to-done latency; result held until the next start.
module bin2bcd_seq
  import hud_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        done
);

  logic [15:0] bcd_q;
  logic [13:0] shift_q;
  logic [3:0]  cnt_q;
  logic        run_q;
  logic        done_q;
  logic [15:0] adj;

  always_comb begin
    adj = bcd_adjust(bcd_q);
  end

  // The first shift happens on the start edge itself, so done lands 14 cycles after start.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        bcd_q   <= {15'd0, bin[13]};
        shift_q <= {bin[12:0], 1'b0};
        cnt_q   <= 4'd13;
        run_q   <= 1'b1;
      end else if (run_q) begin
        bcd_q   <= {adj[14:0], shift_q[13]};
        shift_q <= {shift_q[12:0], 1'b0};
        cnt_q   <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;

endmodule

// File: rtl/hud_score_writer.sv
// Snapshots the score and five 2-digit values, converts each to BCD and
// streams the 14 digit codes to the HUD digit block, MS digit first.
module hud_score_writer
  import hud_pkg::*;
#(
  parameter bit         BLANK_LEADING = 1'b1,
  parameter logic [3:0] BLANK_CODE    = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        update,
  input  logic [13:0] score,
  input  logic [6:0]  val1,
  input  logic [6:0]  val2,
  input  logic [6:0]  val3,
  input  logic [6:0]  val4,
  input  logic [6:0]  val5,
  output logic        write,
  output logic [3:0]  blob,
  output logic [3:0]  num,
  output logic        busy,
  output logic        done
);

  state_t      state_q, state_d;
  logic        pending_q, pending_d;
  logic [13:0] snap_q [NUM_FIELDS];
  logic [2:0]  field_q;
  logic [1:0]  digit_q;
  logic        lead_q;

  logic        conv_start;
  logic [13:0] conv_bin;
  logic [15:0] conv_bcd;
  logic        conv_done;

  logic [1:0]  last_k;
  logic [1:0]  pos;
  logic [3:0]  nibble;
  logic        last_digit;
  logic        blank;

  assign conv_start = (state_q == ST_CONV);

  always_comb begin
    conv_bin = '0;
    case (field_q)
      3'd0:    conv_bin = snap_q[0];
      3'd1:    conv_bin = snap_q[1];
      3'd2:    conv_bin = snap_q[2];
      3'd3:    conv_bin = snap_q[3];
      3'd4:    conv_bin = snap_q[4];
      3'd5:    conv_bin = snap_q[5];
      default: conv_bin = '0;
    endcase
  end

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (conv_bin),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  // k counts from the MS digit, so the BCD nibble position is last_k - k.
  assign last_k     = 2'(DIGIT_CNT[field_q] - 3'd1);
  assign pos        = last_k - digit_q;
  assign nibble     = conv_bcd[{pos, 2'b00} +: 4];
  assign last_digit = (digit_q == last_k);
  assign blank      = BLANK_LEADING && lead_q && (nibble == 4'd0) && !last_digit;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (update && state_q != ST_IDLE) pending_d = 1'b1;
    case (state_q)
      ST_IDLE:  if (update || pending_q) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_CONV;
      ST_CONV:  state_d = ST_WAIT;
      ST_WAIT:  if (conv_done) state_d = ST_WRITE;
      ST_WRITE: if (last_digit) state_d = (field_q == LAST_FIELD) ? ST_DONE : ST_CONV;
      ST_DONE:  state_d = pending_q ? ST_LATCH : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (state_d == ST_LATCH) pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      field_q   <= '0;
      digit_q   <= '0;
      lead_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_FIELDS; i++) snap_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      case (state_q)
        ST_LATCH: begin
          snap_q[0] <= (score > SCORE_MAX) ? SCORE_MAX : score;
          snap_q[1] <= {7'd0, (val1 > VAL_MAX) ? VAL_MAX : val1};
          snap_q[2] <= {7'd0, (val2 > VAL_MAX) ? VAL_MAX : val2};
          snap_q[3] <= {7'd0, (val3 > VAL_MAX) ? VAL_MAX : val3};
          snap_q[4] <= {7'd0, (val4 > VAL_MAX) ? VAL_MAX : val4};
          snap_q[5] <= {7'd0, (val5 > VAL_MAX) ? VAL_MAX : val5};
          field_q   <= '0;
        end
        ST_CONV: begin
          digit_q <= '0;
          lead_q  <= 1'b1;
        end
        ST_WRITE: begin
          digit_q <= digit_q + 2'd1;
          lead_q  <= lead_q && (nibble == 4'd0);
          if (last_digit && field_q != LAST_FIELD) field_q <= field_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign write = (state_q == ST_WRITE);
  assign blob  = write ? (BASE_SLOT[field_q] + {2'b00, digit_q}) : '0;
  assign num   = write ? (blank ? BLANK_CODE : nibble) : '0;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_hud_score_writer.sv
// Directed self-checking bench for hud_score_writer (blanking and non-blanking instances).
module tb_hud_score_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        update = 1'b0;
  logic [13:0] score = '0;
  logic [6:0]  val1 = '0, val2 = '0, val3 = '0, val4 = '0, val5 = '0;

  logic       write_a, busy_a, done_a;
  logic [3:0] blob_a, num_a;
  logic       write_b, busy_b, done_b;
  logic [3:0] blob_b, num_b;

  always #5 clk = ~clk;

  hud_score_writer u_dut_a (
    .clk(clk), .reset(reset), .update(update), .score(score),
    .val1(val1), .val2(val2), .val3(val3), .val4(val4), .val5(val5),
    .write(write_a), .blob(blob_a), .num(num_a), .busy(busy_a), .done(done_a)
  );

  hud_score_writer #(.BLANK_LEADING(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .update(update), .score(score),
    .val1(val1), .val2(val2), .val3(val3), .val4(val4), .val5(val5),
    .write(write_b), .blob(blob_b), .num(num_b), .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int failures = 0;

  int         nw_a, nw_b, nd, bad_idle;
  logic [3:0] wb_a [0:63];
  logic [3:0] wn_a [0:63];
  int         wc_a [0:63];
  logic [3:0] wb_b [0:63];
  logic [3:0] wn_b [0:63];
  int         dc   [0:7];
  logic       busy_h [0:255];

  logic [3:0] EXP1  [0:13] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'hF, 4'd7, 4'hF, 4'd0, 4'd9, 4'd9, 4'd4, 4'd2};
  logic [3:0] EXP1B [0:13] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd7, 4'd0, 4'd0, 4'd9, 4'd9, 4'd4, 4'd2};
  int         EXPC  [0:13] = '{17, 18, 19, 20, 36, 37, 53, 54, 70, 71, 87, 88, 104, 105};

  task automatic set_inputs(input logic [13:0] s, input logic [6:0] a, input logic [6:0] b,
                            input logic [6:0] c, input logic [6:0] d, input logic [6:0] e);
    score = s; val1 = a; val2 = b; val3 = c; val4 = d; val5 = e;
  endtask

  // Pulses update in cycle 0, then samples outputs at each negedge for cycles 1..ncyc.
  task automatic run_seq(input int ncyc, input int upd2, input int upd3, input int rst_at,
                         input int chg_at, input logic [13:0] chg_score, input logic [6:0] chg_v5);
    nw_a = 0; nw_b = 0; nd = 0; bad_idle = 0;
    @(negedge clk);
    update = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (write_a) begin
        if (nw_a < 64) begin wb_a[nw_a] = blob_a; wn_a[nw_a] = num_a; wc_a[nw_a] = c; end
        nw_a++;
      end else if (blob_a != 4'd0 || num_a != 4'd0) bad_idle++;
      if (write_b) begin
        if (nw_b < 64) begin wb_b[nw_b] = blob_b; wn_b[nw_b] = num_b; end
        nw_b++;
      end
      if (done_a) begin
        if (nd < 8) dc[nd] = c;
        nd++;
      end
      if (c < 256) busy_h[c] = busy_a;
      update = (c == upd2) || (c == upd3);
      reset  = (c == rst_at);
      if (c == chg_at) begin score = chg_score; val5 = chg_v5; end
    end
    update = 1'b0;
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    int wr_seen, busy_seen;
    update = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({write_a, busy_a, done_a, blob_a, num_a} !== 11'd0) begin
        $display("FAIL reset_outputs got=%b exp=0", {write_a, busy_a, done_a, blob_a, num_a});
        failures++;
      end
    end
    @(negedge clk);
    reset = 1'b0; update = 1'b0;
    wr_seen = 0; busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (write_a || write_b) wr_seen++;
      if (busy_a || busy_b) busy_seen++;
    end
    checks++;
    if (wr_seen !== 0) begin $display("FAIL reset_no_write got=%0d exp=0", wr_seen); failures++; end
    checks++;
    if (busy_seen !== 0) begin $display("FAIL reset_idle_busy got=%0d exp=0", busy_seen); failures++; end
  endtask

  task automatic test_scenario1();
    set_inputs(14'd1234, 7'd56, 7'd7, 7'd0, 7'd99, 7'd42);
    run_seq(120, -1, -1, -1, -1, 14'd0, 7'd0);
    checks++;
    if (nw_a !== 14) begin $display("FAIL s1_write_count got=%0d exp=14", nw_a); failures++; end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (wb_a[i] !== 4'(i) || wn_a[i] !== EXP1[i]) begin
        $display("FAIL s1_slot%0d got=%0d:%h exp=%0d:%h", i, wb_a[i], wn_a[i], i, EXP1[i]); failures++;
      end
      checks++;
      if (wc_a[i] !== EXPC[i]) begin
        $display("FAIL s1_cycle%0d got=%0d exp=%0d", i, wc_a[i], EXPC[i]); failures++;
      end
      checks++;
      if (wb_b[i] !== 4'(i) || wn_b[i] !== EXP1B[i]) begin
        $display("FAIL s1_noblank_slot%0d got=%0d:%h exp=%0d:%h", i, wb_b[i], wn_b[i], i, EXP1B[i]); failures++;
      end
    end
    checks++;
    if (nd !== 1 || dc[0] !== 106) begin $display("FAIL s1_done got=%0d@%0d exp=1@106", nd, dc[0]); failures++; end
    checks++;
    if ({busy_h[1], busy_h[106], busy_h[107]} !== 3'b110) begin
      $display("FAIL s1_busy got=%b exp=110", {busy_h[1], busy_h[106], busy_h[107]}); failures++;
    end
    checks++;
    if (bad_idle !== 0) begin $display("FAIL s1_idle_outputs got=%0d exp=0", bad_idle); failures++; end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_n [0:13] = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'hF, 4'd0, 4'hF, 4'd9};
    set_inputs(14'd12000, 7'd127, 7'd100, 7'd99, 7'd0, 7'd9);
    run_seq(120, -1, -1, -1, -1, 14'd0, 7'd0);
    checks++;
    if (nw_a !== 14) begin $display("FAIL sat_write_count got=%0d exp=14", nw_a); failures++; end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (wb_a[i] !== 4'(i) || wn_a[i] !== exp_n[i]) begin
        $display("FAIL sat_slot%0d got=%0d:%h exp=%0d:%h", i, wb_a[i], wn_a[i], i, exp_n[i]); failures++;
      end
    end
  endtask

  task automatic test_no_blank();
    logic [3:0] exp_a [0:13] = '{4'hF, 4'hF, 4'hF, 4'd7, 4'd1, 4'd0, 4'hF, 4'd5, 4'hF, 4'd0, 4'hF, 4'd0, 4'hF, 4'd0};
    logic [3:0] exp_b [0:13] = '{4'd0, 4'd0, 4'd0, 4'd7, 4'd1, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    set_inputs(14'd7, 7'd10, 7'd5, 7'd0, 7'd0, 7'd0);
    run_seq(120, -1, -1, -1, -1, 14'd0, 7'd0);
    checks++;
    if (nw_b !== 14) begin $display("FAIL nb_write_count got=%0d exp=14", nw_b); failures++; end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (wb_b[i] !== 4'(i) || wn_b[i] !== exp_b[i]) begin
        $display("FAIL nb_slot%0d got=%0d:%h exp=%0d:%h", i, wb_b[i], wn_b[i], i, exp_b[i]); failures++;
      end
      checks++;
      if (wb_a[i] !== 4'(i) || wn_a[i] !== exp_a[i]) begin
        $display("FAIL blank_slot%0d got=%0d:%h exp=%0d:%h", i, wb_a[i], wn_a[i], i, exp_a[i]); failures++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int gaps;
    set_inputs(14'd1234, 7'd56, 7'd7, 7'd0, 7'd99, 7'd42);
    run_seq(230, 40, 60, -1, -1, 14'd0, 7'd0);
    checks++;
    if (nd !== 2 || dc[0] !== 106 || dc[1] !== 212) begin
      $display("FAIL b2b_done got=%0d@%0d,%0d exp=2@106,212", nd, dc[0], dc[1]); failures++;
    end
    checks++;
    if (nw_a !== 28) begin $display("FAIL b2b_write_count got=%0d exp=28", nw_a); failures++; end
    checks++;
    if (wc_a[14] !== 123) begin $display("FAIL b2b_second_first_write got=%0d exp=123", wc_a[14]); failures++; end
    gaps = 0;
    for (int c = 1; c <= 212; c++) if (busy_h[c] !== 1'b1) gaps++;
    checks++;
    if (gaps !== 0) begin $display("FAIL b2b_busy_gap got=%0d exp=0", gaps); failures++; end
    checks++;
    if (busy_h[213] !== 1'b0) begin $display("FAIL b2b_idle_after got=%b exp=0", busy_h[213]); failures++; end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (wb_a[14+i] !== 4'(i) || wn_a[14+i] !== EXP1[i]) begin
        $display("FAIL b2b_slot%0d got=%0d:%h exp=%0d:%h", i, wb_a[14+i], wn_a[14+i], i, EXP1[i]); failures++;
      end
    end
  endtask

  task automatic test_reset_midpass();
    int busy_after;
    set_inputs(14'd1234, 7'd56, 7'd7, 7'd0, 7'd99, 7'd42);
    run_seq(150, -1, -1, 50, -1, 14'd0, 7'd0);
    checks++;
    if (nw_a !== 6) begin $display("FAIL rst_write_count got=%0d exp=6", nw_a); failures++; end
    checks++;
    if (busy_h[51] !== 1'b0) begin $display("FAIL rst_busy51 got=%b exp=0", busy_h[51]); failures++; end
    checks++;
    if (nd !== 0) begin $display("FAIL rst_done got=%0d exp=0", nd); failures++; end
    busy_after = 0;
    for (int c = 51; c <= 150; c++) if (busy_h[c] !== 1'b0) busy_after++;
    checks++;
    if (busy_after !== 0) begin $display("FAIL rst_busy_after got=%0d exp=0", busy_after); failures++; end
    run_seq(120, -1, -1, -1, -1, 14'd0, 7'd0);
    checks++;
    if (nw_a !== 14 || nd !== 1 || dc[0] !== 106) begin
      $display("FAIL rst_fresh_pass got=%0d/%0d@%0d exp=14/1@106", nw_a, nd, dc[0]); failures++;
    end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (wb_a[i] !== 4'(i) || wn_a[i] !== EXP1[i]) begin
        $display("FAIL rst_slot%0d got=%0d:%h exp=%0d:%h", i, wb_a[i], wn_a[i], i, EXP1[i]); failures++;
      end
    end
  endtask

  task automatic test_snapshot();
    set_inputs(14'd1234, 7'd56, 7'd7, 7'd0, 7'd99, 7'd42);
    run_seq(120, -1, -1, -1, 30, 14'd5678, 7'd11);
    checks++;
    if (nw_a !== 14) begin $display("FAIL snap_write_count got=%0d exp=14", nw_a); failures++; end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (wb_a[i] !== 4'(i) || wn_a[i] !== EXP1[i]) begin
        $display("FAIL snap_slot%0d got=%0d:%h exp=%0d:%h", i, wb_a[i], wn_a[i], i, EXP1[i]); failures++;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_scenario1();
    test_saturation();
    test_no_blank();
    test_back_to_back();
    test_reset_midpass();
    test_snapshot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
